icache_direct: RTL and testbench

Blocking, direct-mapped 4 KB instruction cache between the fetch stage's pre-IF request port and the AXI bridge read port. It accepts one {tag,index,offset} request per cycle on hits, refills 16-byte lines on misses, and serves kseg1 (uncached) fetches as single-word bypass reads. Every accepted request returns exactly one data_ok, in order; requests are never cancelled.

---
 rtl/icache_direct.sv | 176 +++++++++++++++++
 tb/tb_icache_direct.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Blocking direct-mapped 4 KB instruction cache (256 x 16 B lines) with kseg1 bypass reads.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_direct (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic        uncache,
    input  logic [19:0] tag,
    input  logic [7:0]  index,
    input  logic [3:0]  offset,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        rd_req,
    output logic        rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMiss,
        StRefill,
        StWrite
    } state_e;

    state_e state_q, state_d;

    logic [19:0]  req_tag_q;
    logic [7:0]   req_index_q;
    logic [3:0]   req_offset_q;
    logic         req_uncache_q;

    logic [255:0] valid_bits_q;
    logic [19:0]  tag_ram  [256];
    logic [127:0] data_ram [256];
    logic [19:0]  tag_rd_q;
    logic [127:0] line_rd_q;

    logic [1:0]   cnt_q;
    logic [127:0] line_q;

    logic hit;
    logic accept;
    logic refill_beat;
    logic crit_beat;

    assign hit = (state_q == StLookup) & valid_bits_q[req_index_q] &
                 (tag_rd_q == req_tag_q) & ~req_uncache_q;
    assign accept      = valid & ((state_q == StIdle) | hit);
    assign refill_beat = (state_q == StRefill) & ret_valid;
    // Uncached reads return a single beat; cached reads forward the requested word early.
    assign crit_beat   = refill_beat &
                         (req_uncache_q ? ret_last : (cnt_q == req_offset_q[3:2]));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StLookup;
            end
            StLookup: begin
                if (hit) state_d = accept ? StLookup : StIdle;
                else     state_d = StMiss;
            end
            StMiss: begin
                if (rd_rdy) state_d = StRefill;
            end
            StRefill: begin
                if (ret_valid && ret_last) state_d = req_uncache_q ? StIdle : StWrite;
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        addr_ok = accept;
        data_ok = hit | crit_beat;
        rdata   = 32'h0;
        if (hit) begin
            rdata = line_rd_q[{req_offset_q[3:2], 5'b0} +: 32];
        end else if (crit_beat) begin
            rdata = ret_data;
        end
        rd_req  = (state_q == StMiss);
        rd_type = (state_q == StMiss) & ~req_uncache_q;
        rd_addr = {req_tag_q, req_index_q, req_uncache_q ? req_offset_q : 4'b0};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_tag_q     <= 20'h0;
            req_index_q   <= 8'h0;
            req_offset_q  <= 4'h0;
            req_uncache_q <= 1'b0;
        end else if (accept) begin
            req_tag_q     <= tag;
            req_index_q   <= index;
            req_offset_q  <= offset;
            req_uncache_q <= uncache;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= 2'd0;
            line_q <= 128'h0;
        end else if (state_q == StMiss) begin
            cnt_q <= 2'd0;
        end else if (refill_beat) begin
            cnt_q                       <= cnt_q + 2'd1;
            line_q[{cnt_q, 5'b0} +: 32] <= ret_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_bits_q <= 256'h0;
        end else if (state_q == StWrite) begin
            valid_bits_q[req_index_q] <= 1'b1;
        end
    end

    // RAM write (WRITE) and read (acceptance) never coincide since WRITE accepts nothing.
    always_ff @(posedge clk) begin
        if (state_q == StWrite) begin
            tag_ram[req_index_q]  <= req_tag_q;
            data_ram[req_index_q] <= line_q;
        end
        if (accept) begin
            tag_rd_q  <= tag_ram[index];
            line_rd_q <= data_ram[index];
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            if ((state_q == StLookup) && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct: miss, hit stream, conflict, bypass,
// bridge stall and reset during refill.
module tb_icache_direct;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic        uncache;
    logic [19:0] tag;
    logic [7:0]  index;
    logic [3:0]  offset;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        rd_req;
    logic        rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_cmp;
    int n_fail;

    logic        f_acc;
    logic        f_done;
    int          f_req_first;
    int          f_n_req;
    logic [31:0] f_req_addr;
    logic        f_req_type;
    logic        f_unstable;
    int          f_n_aok;
    int          f_n_dok;
    int          f_n_dok_pre;
    int          f_dok_beat;
    logic [31:0] f_dok_data;

    icache_direct dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .uncache   (uncache),
        .tag       (tag),
        .index     (index),
        .offset    (offset),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [31:0] a);
        tag    = a[31:12];
        index  = a[11:4];
        offset = a[3:0];
    endtask

    // Issues one request from IDLE, plays the bridge side and records what it observed.
    task automatic fetch(input logic [31:0] addr, input logic unc, input logic [127:0] beats,
                         input int rdy_delay, input logic hold_valid);
        int   phase;
        int   beat;
        logic last;
        f_acc = 0; f_done = 0; f_req_first = -1; f_n_req = 0; f_req_addr = 0;
        f_req_type = 0; f_unstable = 0; f_n_aok = 0; f_n_dok = 0; f_n_dok_pre = 0;
        f_dok_beat = -1; f_dok_data = 0;
        last = 0;
        valid = 1; uncache = unc; set_addr(addr);
        rd_rdy = 0; ret_valid = 0; ret_last = 0;
        @(negedge clk);
        f_acc = addr_ok;
        tick();
        valid = hold_valid;
        phase = 0;
        beat  = 0;
        for (int cyc = 1; cyc <= 40 && !f_done; cyc++) begin
            if (phase == 0) begin
                rd_rdy    = (f_n_req >= rdy_delay);
                ret_valid = 0;
                ret_last  = 0;
            end else begin
                rd_rdy    = 0;
                ret_valid = 1;
                ret_data  = beats[beat*32 +: 32];
                last      = unc || (beat == 3);
                ret_last  = last;
            end
            @(negedge clk);
            if (phase == 0 && valid && addr_ok) f_n_aok++;
            if (rd_req) begin
                if (f_n_req == 0) begin
                    f_req_first = cyc;
                    f_req_addr  = rd_addr;
                    f_req_type  = rd_type;
                end else if (rd_addr !== f_req_addr || rd_type !== f_req_type) begin
                    f_unstable = 1;
                end
                f_n_req++;
            end
            if (data_ok) begin
                f_n_dok++;
                f_dok_data = rdata;
                if (phase == 0) f_n_dok_pre++;
                else            f_dok_beat = beat;
            end
            if (phase == 0) begin
                if (rd_req && rd_rdy) begin
                    phase = 1;
                    valid = 0;
                end else if (data_ok) begin
                    f_done = 1;
                end
            end else begin
                if (last) f_done = 1;
                beat++;
            end
            tick();
        end
        valid = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0;
    endtask

    task automatic test_reset();
        resetn = 0; valid = 1; uncache = 0; set_addr(32'h1fc00004);
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL reset_addr_ok got %0b exp 1", addr_ok); end
        n_cmp++; if (data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok got %0b exp 0", data_ok); end
        n_cmp++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req got %0b exp 0", rd_req); end
        n_cmp++; if (rd_type !== 1'b0) begin n_fail++; $display("FAIL reset_rd_type got %0b exp 0", rd_type); end
        n_cmp++; if (rd_addr !== 32'h0) begin n_fail++; $display("FAIL reset_rd_addr got %h exp 0", rd_addr); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
`ifdef ICACHE_PERF_EN
        n_cmp++; if (hit_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_hit_cnt got %0d exp 0", hit_cnt); end
        n_cmp++; if (miss_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_miss_cnt got %0d exp 0", miss_cnt); end
`endif
        valid = 0;
        tick();
        resetn = 1;
        tick();
    endtask

    task automatic test_cold_miss();
        fetch(32'h1fc00004, 1'b0, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b0);
        n_cmp++; if (f_done !== 1'b1) begin n_fail++; $display("FAIL cold_done got %0b exp 1", f_done); end
        n_cmp++; if (f_acc !== 1'b1) begin n_fail++; $display("FAIL cold_accept got %0b exp 1", f_acc); end
        n_cmp++; if (f_req_first !== 2) begin n_fail++; $display("FAIL cold_req_cycle got %0d exp 2", f_req_first); end
        n_cmp++; if (f_req_type !== 1'b1) begin n_fail++; $display("FAIL cold_rd_type got %0b exp 1", f_req_type); end
        n_cmp++; if (f_req_addr !== 32'h1fc00000) begin n_fail++; $display("FAIL cold_rd_addr got %h exp 1fc00000", f_req_addr); end
        n_cmp++; if (f_n_dok !== 1) begin n_fail++; $display("FAIL cold_dok_count got %0d exp 1", f_n_dok); end
        n_cmp++; if (f_dok_beat !== 1) begin n_fail++; $display("FAIL cold_crit_beat got %0d exp 1", f_dok_beat); end
        n_cmp++; if (f_dok_data !== 32'h22) begin n_fail++; $display("FAIL cold_rdata got %h exp 22", f_dok_data); end
        // Now in WRITE: a pending request must wait one more cycle.
        valid = 1; uncache = 0; set_addr(32'h1fc00000);
        @(negedge clk);
        n_cmp++; if (addr_ok !== 1'b0) begin n_fail++; $display("FAIL cold_write_addr_ok got %0b exp 0", addr_ok); end
        tick();
        @(negedge clk);
        n_cmp++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL cold_idle_addr_ok got %0b exp 1", addr_ok); end
        valid = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
        uncache = 0;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                valid = 1;
                set_addr(32'h1fc00000 + 32'(4 * c));
            end else begin
                valid = 0;
            end
            @(negedge clk);
            if (c < 4) begin
                n_cmp++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL hit_addr_ok[%0d] got %0b exp 1", c, addr_ok); end
            end
            if (c > 0) begin
                n_cmp++; if (data_ok !== 1'b1) begin n_fail++; $display("FAIL hit_data_ok[%0d] got %0b exp 1", c, data_ok); end
                n_cmp++; if (rdata !== exp_w[c-1]) begin n_fail++; $display("FAIL hit_rdata[%0d] got %h exp %h", c, rdata, exp_w[c-1]); end
            end else begin
                n_cmp++; if (data_ok !== 1'b0) begin n_fail++; $display("FAIL hit_data_ok[0] got %0b exp 0", data_ok); end
            end
            n_cmp++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL hit_rd_req[%0d] got %0b exp 0", c, rd_req); end
            tick();
        end
`ifdef ICACHE_PERF_EN
        n_cmp++; if (hit_cnt !== 32'd4) begin n_fail++; $display("FAIL hit_cnt got %0d exp 4", hit_cnt); end
        n_cmp++; if (miss_cnt !== 32'd1) begin n_fail++; $display("FAIL hit_miss_cnt got %0d exp 1", miss_cnt); end
`endif
    endtask

    task automatic test_conflict();
        fetch(32'h00001000, 1'b0, {32'ha3, 32'ha2, 32'ha1, 32'ha0}, 0, 1'b0);
        n_cmp++; if (f_n_req !== 1) begin n_fail++; $display("FAIL conf_miss_req got %0d exp 1", f_n_req); end
        n_cmp++; if (f_req_addr !== 32'h00001000) begin n_fail++; $display("FAIL conf_rd_addr got %h exp 00001000", f_req_addr); end
        n_cmp++; if (f_dok_data !== 32'ha0) begin n_fail++; $display("FAIL conf_rdata got %h exp a0", f_dok_data); end
        n_cmp++; if (f_dok_beat !== 0) begin n_fail++; $display("FAIL conf_crit_beat got %0d exp 0", f_dok_beat); end
        tick();
        fetch(32'h1fc00008, 1'b0, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b0);
        n_cmp++; if (f_n_req !== 1) begin n_fail++; $display("FAIL conf_refetch_req got %0d exp 1", f_n_req); end
        n_cmp++; if (f_n_dok_pre !== 0) begin n_fail++; $display("FAIL conf_refetch_hit got %0d exp 0", f_n_dok_pre); end
        n_cmp++; if (f_dok_data !== 32'h33) begin n_fail++; $display("FAIL conf_refetch_rdata got %h exp 33", f_dok_data); end
        tick();
    endtask

    task automatic test_uncached();
        fetch(32'h1fc00380, 1'b1, {96'h0, 32'hdead0001}, 0, 1'b0);
        n_cmp++; if (f_req_type !== 1'b0) begin n_fail++; $display("FAIL unc_rd_type got %0b exp 0", f_req_type); end
        n_cmp++; if (f_req_addr !== 32'h1fc00380) begin n_fail++; $display("FAIL unc_rd_addr got %h exp 1fc00380", f_req_addr); end
        n_cmp++; if (f_n_dok !== 1) begin n_fail++; $display("FAIL unc_dok_count got %0d exp 1", f_n_dok); end
        n_cmp++; if (f_dok_beat !== 0) begin n_fail++; $display("FAIL unc_dok_beat got %0d exp 0", f_dok_beat); end
        n_cmp++; if (f_dok_data !== 32'hdead0001) begin n_fail++; $display("FAIL unc_rdata got %h exp dead0001", f_dok_data); end
        fetch(32'h1fc00380, 1'b1, {96'h0, 32'hdead0002}, 0, 1'b0);
        n_cmp++; if (f_acc !== 1'b1) begin n_fail++; $display("FAIL unc_next_accept got %0b exp 1", f_acc); end
        n_cmp++; if (f_n_req !== 1) begin n_fail++; $display("FAIL unc_repeat_req got %0d exp 1", f_n_req); end
        n_cmp++; if (f_dok_data !== 32'hdead0002) begin n_fail++; $display("FAIL unc_repeat_rdata got %h exp dead0002", f_dok_data); end
    endtask

    task automatic test_stall();
        fetch(32'h1fc00010, 1'b0, {32'hc3, 32'hc2, 32'hc1, 32'hc0}, 5, 1'b1);
        n_cmp++; if (f_n_req !== 6) begin n_fail++; $display("FAIL stall_req_cycles got %0d exp 6", f_n_req); end
        n_cmp++; if (f_unstable !== 1'b0) begin n_fail++; $display("FAIL stall_req_stable got %0b exp 0", f_unstable); end
        n_cmp++; if (f_req_addr !== 32'h1fc00010) begin n_fail++; $display("FAIL stall_rd_addr got %h exp 1fc00010", f_req_addr); end
        n_cmp++; if (f_n_aok !== 0) begin n_fail++; $display("FAIL stall_addr_ok got %0d exp 0", f_n_aok); end
        n_cmp++; if (f_n_dok_pre !== 0) begin n_fail++; $display("FAIL stall_early_dok got %0d exp 0", f_n_dok_pre); end
        n_cmp++; if (f_dok_data !== 32'hc0) begin n_fail++; $display("FAIL stall_rdata got %h exp c0", f_dok_data); end
        tick();
    endtask

    task automatic test_reset_refill();
        valid = 1; uncache = 0; set_addr(32'h1fc00024);
        @(negedge clk);
        tick();
        valid = 0;
        tick();
        rd_rdy = 1;
        @(negedge clk);
        n_cmp++; if (rd_req !== 1'b1) begin n_fail++; $display("FAIL rst_rd_req got %0b exp 1", rd_req); end
        tick();
        rd_rdy = 0; ret_valid = 1; ret_last = 0; ret_data = 32'h55;
        @(negedge clk);
        n_cmp++; if (data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_beat0_dok got %0b exp 0", data_ok); end
        tick();
        ret_data = 32'h66;
        #2 resetn = 0;
        @(negedge clk);
        n_cmp++; if (data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_crit_dok got %0b exp 0", data_ok); end
        #1 resetn = 1;
        tick();
        ret_data = 32'h88; ret_last = 1;
        @(negedge clk);
        n_cmp++; if (data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_stale_dok got %0b exp 0", data_ok); end
        n_cmp++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL rst_stale_rd_req got %0b exp 0", rd_req); end
        tick();
        ret_valid = 0; ret_last = 0;
        fetch(32'h1fc00024, 1'b0, {32'hf3, 32'hf2, 32'hf1, 32'hf0}, 0, 1'b0);
        n_cmp++; if (f_n_req !== 1) begin n_fail++; $display("FAIL rst_refetch_req got %0d exp 1", f_n_req); end
        n_cmp++; if (f_req_addr !== 32'h1fc00020) begin n_fail++; $display("FAIL rst_refetch_addr got %h exp 1fc00020", f_req_addr); end
        n_cmp++; if (f_n_dok !== 1) begin n_fail++; $display("FAIL rst_refetch_dok got %0d exp 1", f_n_dok); end
        n_cmp++; if (f_dok_data !== 32'hf1) begin n_fail++; $display("FAIL rst_refetch_rdata got %h exp f1", f_dok_data); end
`ifdef ICACHE_PERF_EN
        n_cmp++; if (miss_cnt !== 32'd1) begin n_fail++; $display("FAIL rst_miss_cnt got %0d exp 1", miss_cnt); end
        n_cmp++; if (hit_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_hit_cnt got %0d exp 0", hit_cnt); end
`endif
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_uncached();
        test_stall();
        test_reset_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
